handshake_const_sink: RTL and testbench
=======================================

# handshake_const_sink

Elastic-channel sink that terminates the outs/outs_valid/outs_ready channel of a constant-token source. It consumes tokens under a configurable back-pressure pattern, counts them, and checks each against an expected constant. It sits at the consumer end of constant-source channels in dataflow fabrics and in on-chip self-test harnesses. It flags any divergence and reports completion after a programmed token count.

## Interface
- DATA_WIDTH, 32, token width
- EXPECTED, 21'b010100111110010011000 (0x0A7C98), expected token value; zero-extended to DATA_WIDTH
- CNT_WIDTH, 16, width of token and index counters
- EXPECT_COUNT, 8, tokens to accept before done; 0 = unbounded
- STALL_CYCLES, 2, ins_ready low cycles after each accepted token (stall feature only)

- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- ins  input  DATA_WIDTH  token data
- ins_valid  input  1  token valid
- ins_ready  output  1  sink ready
- count  output  CNT_WIDTH  tokens accepted since reset
- mismatch  output  1  sticky: some accepted token != EXPECTED
- first_bad  output  DATA_WIDTH  value of first mismatching token
- first_bad_idx  output  CNT_WIDTH  0-based index of first mismatching token
- done  output  1  EXPECT_COUNT tokens accepted

## Operation
- Transfer: ins_valid && ins_ready at a rising clk edge while rst low. No other event consumes a token.
- FSM states: ACCEPT, STALL, DONE. Reset state is ACCEPT.
- ins_ready is a Moore decode: 1 in ACCEPT, 0 in STALL and DONE. There is no combinational path from ins_valid to ins_ready.
- ACCEPT on transfer, evaluated in priority order:
  - If EXPECT_COUNT != 0 and count+1 == EXPECT_COUNT, go to DONE.
  - Else, if STALL_CYCLES > 0, go to STALL and load the stall counter with STALL_CYCLES.
  - Else, stay in ACCEPT.
- STALL: decrement the stall counter every cycle. Return to ACCEPT on the cycle the counter reads 1, so ins_ready is low for exactly STALL_CYCLES cycles.
- DONE: terminal. ins_ready stays 0 and done stays 1 until reset.
- count increments by 1 per transfer. When EXPECT_COUNT = 0 it wraps modulo 2^CNT_WIDTH.
- Check: compare the full DATA_WIDTH of ins against zero-extended EXPECTED on every transfer.
  - On the first mismatch, set mismatch, latch first_bad = ins and first_bad_idx = count (pre-increment value).
  - Later mismatches leave first_bad and first_bad_idx unchanged.
  - Mismatches never stall or block acceptance.
- Reset values: ins_ready 1, count 0, mismatch 0, first_bad 0, first_bad_idx 0, done 0, stall counter 0.
- Reset asserted mid-operation (including in STALL or DONE) returns to ACCEPT immediately. No transfer is recorded while rst is high.

## Timing
- All outputs are registered or decoded from the state register. count, mismatch and done update one edge after the transfer.
- Throughput with STALL_CYCLES = 0: one token per cycle. With STALL_CYCLES = N: one token per N+1 cycles.
- ins_valid held high with ins_ready low is legal. The token is taken at the first edge where ins_ready = 1.
- done rises on the edge of the EXPECT_COUNT-th transfer. ins_ready is 0 from the next cycle.
- If the EXPECT_COUNT-th token also mismatches, mismatch and done rise on the same edge.

## Configuration
- Macro: HANDSHAKE_CONST_SINK_STALL_EN.
- Defined: STALL state, stall counter and STALL_CYCLES throttling are compiled in as described.
- Undefined: there is no STALL state and no stall counter, and STALL_CYCLES is ignored. ins_ready is 1 in ACCEPT and 0 only in DONE, giving one token per cycle.

## Test plan
- Default parameters, stall enabled, ins = 0x0A7C98 with ins_valid held high:
  - ins_ready pattern is 1,0,0 repeating.
  - 8 tokens accepted by cycle 22 after reset release.
  - done = 1 and count = 8, with ins_ready = 0 thereafter; mismatch = 0.
- Token index 3 = 0x0A7C99 and index 5 = 0x000000, all others correct:
  - mismatch = 1, first_bad = 0x0A7C99, first_bad_idx = 3, done = 1 after the 8th token.
- Stall disabled, EXPECT_COUNT = 0, CNT_WIDTH = 4, continuous valid:
  - ins_ready stays 1 and count wraps 15 -> 0 on the 16th transfer.
  - done stays 0.
- ins_valid toggling 1,0,1,0 with stall enabled:
  - No token is lost or double-counted; count equals the number of valid-and-ready edges.
- rst pulsed high while in STALL after 4 tokens:
  - All outputs return to reset values asynchronously and ins_ready = 1.
  - count restarts at 0; the first token after release is index 0.
- Last token (index 7) mismatching:
  - mismatch and done rise on the same edge, with first_bad_idx = 7.

Source files
------------

// File: rtl/handshake_const_sink.sv
// handshake_const_sink: consumes constant-source tokens, counts them, checks each against EXPECTED.
// Latency: count/mismatch/first_bad/done update one edge after the transfer; ins_ready is a Moore decode of state.
// Backpressure: ins_ready low for STALL_CYCLES cycles after each token (HANDSHAKE_CONST_SINK_STALL_EN) and permanently in DONE.
//
// Optional feature macro: HANDSHAKE_CONST_SINK_STALL_EN
//   defined   -> STALL state and stall counter are built; one token per STALL_CYCLES+1 cycles
//   undefined -> no STALL state, STALL_CYCLES ignored; one token per cycle until DONE

module handshake_const_sink #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECTED     = DATA_WIDTH'(21'b010100111110010011000),
    parameter int                    CNT_WIDTH    = 16,
    parameter int                    EXPECT_COUNT = 8,
    parameter int                    STALL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  mismatch,
    output logic [DATA_WIDTH-1:0] first_bad,
    output logic [CNT_WIDTH-1:0]  first_bad_idx,
    output logic                  done
);

    // A zero EXPECT_COUNT means the sink never terminates and count simply wraps.
    localparam bit BOUNDED = (EXPECT_COUNT != 0);

`ifdef HANDSHAKE_CONST_SINK_STALL_EN
    // Stall counter only needs to hold STALL_CYCLES; keep at least one bit.
    localparam int SCW = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
    localparam logic [SCW-1:0] STALL_LOAD = SCW'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_STALL  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DONE   = 1'b1
    } state_t;
`endif

    state_t state;
    state_t state_nxt;

    logic xfer;
    logic last_token;
    logic token_bad;

    // A token moves only when the sink advertises ready; data never affects readiness.
    assign xfer       = ins_valid && ins_ready;
    // Compare in 32 bits so an EXPECT_COUNT at the top of the counter range still matches.
    assign last_token = BOUNDED && ((32'(count) + 32'd1) == 32'(EXPECT_COUNT));
    // Full-width compare against the zero-extended constant.
    assign token_bad  = (ins != EXPECTED);

`ifdef HANDSHAKE_CONST_SINK_STALL_EN
    logic [SCW-1:0] stall_cnt;
`endif

    // State register: reset lands in ACCEPT so the sink is ready straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: terminating on the final token wins over entering a stall.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCEPT: begin
                if (xfer) begin
                    if (last_token) begin
                        state_nxt = ST_DONE;
                    end
`ifdef HANDSHAKE_CONST_SINK_STALL_EN
                    else if (STALL_CYCLES > 0) begin
                        state_nxt = ST_STALL;
                    end
`endif
                end
            end
`ifdef HANDSHAKE_CONST_SINK_STALL_EN
            // Leave on the cycle the counter reads 1 so ready is low exactly STALL_CYCLES cycles.
            // The <= guard also recovers if the counter were ever seen at 0.
            ST_STALL: begin
                if (stall_cnt <= SCW'(1)) begin
                    state_nxt = ST_ACCEPT;
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_ACCEPT;
            end
        endcase
    end

    // Outputs: pure decode of the state register, no path from ins_valid.
    always_comb begin
        ins_ready = (state == ST_ACCEPT);
        done      = (state == ST_DONE);
    end

`ifdef HANDSHAKE_CONST_SINK_STALL_EN
    // Stall counter: loaded on a non-final transfer, counts down while stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == ST_ACCEPT) begin
            if (xfer && !last_token && (STALL_CYCLES > 0)) begin
                stall_cnt <= STALL_LOAD;
            end
        end else if (state == ST_STALL) begin
            if (stall_cnt != '0) begin
                stall_cnt <= stall_cnt - SCW'(1);
            end
        end
    end
`endif

    // Token counter: one per transfer, naturally wraps when the sink is unbounded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (xfer) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // Divergence capture: only the first bad token is recorded; later ones just keep the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch      <= 1'b0;
            first_bad     <= '0;
            first_bad_idx <= '0;
        end else if (xfer && token_bad && !mismatch) begin
            mismatch      <= 1'b1;
            first_bad     <= ins;
            first_bad_idx <= count;
        end
    end

endmodule

// File: tb/tb_handshake_const_sink.sv
// Randomized self-checking bench for handshake_const_sink.
// A token-level model (accepted count, cycles since last accept, first-bad record) predicts every output.
// A second instance covers the unbounded, narrow-counter, no-stall configuration.

module tb_handshake_const_sink;

    localparam int DW  = 32;
    localparam int CW  = 16;
    localparam int EC  = 8;
    localparam int SC  = 2;
    localparam int CW2 = 4;
    localparam logic [DW-1:0] EXP = 32'h000A7C98;
`ifdef HANDSHAKE_CONST_SINK_STALL_EN
    localparam int SE = SC;
`else
    localparam int SE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ins = EXP;
    logic          ins_valid = 1'b0;
    logic          ins_ready;
    logic [CW-1:0] count;
    logic          mismatch;
    logic [DW-1:0] first_bad;
    logic [CW-1:0] first_bad_idx;
    logic          done;

    logic [DW-1:0]  ins2 = EXP;
    logic           ins_valid2 = 1'b0;
    logic           ins_ready2;
    logic [CW2-1:0] count2;
    logic           mismatch2;
    logic [DW-1:0]  first_bad2;
    logic [CW2-1:0] first_bad_idx2;
    logic           done2;

    handshake_const_sink #(
        .DATA_WIDTH(DW), .EXPECTED(EXP), .CNT_WIDTH(CW),
        .EXPECT_COUNT(EC), .STALL_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .count(count), .mismatch(mismatch), .first_bad(first_bad),
        .first_bad_idx(first_bad_idx), .done(done)
    );

    handshake_const_sink #(
        .DATA_WIDTH(DW), .EXPECTED(EXP), .CNT_WIDTH(CW2),
        .EXPECT_COUNT(0), .STALL_CYCLES(0)
    ) dut2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(ins_valid2), .ins_ready(ins_ready2),
        .count(count2), .mismatch(mismatch2), .first_bad(first_bad2),
        .first_bad_idx(first_bad_idx2), .done(done2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Token-level reference state.
    int            m_count;
    int            m_gap;
    logic          m_mis;
    logic [DW-1:0] m_fb;
    int            m_fi;

    function automatic logic m_done();
        return (EC != 0) && (m_count == EC);
    endfunction

    // Ready when not finished and at least SE full cycles have passed since the last token.
    function automatic logic m_ready();
        return !m_done() && (m_gap >= SE);
    endfunction

    function automatic logic [66:0] exp_vec();
        return {m_ready(), CW'(m_count), m_mis, m_fb, CW'(m_fi), m_done()};
    endfunction

    function automatic logic [66:0] act_vec();
        return {ins_ready, count, mismatch, first_bad, first_bad_idx, done};
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_gap   = 1000;
        m_mis   = 1'b0;
        m_fb    = '0;
        m_fi    = 0;
    endtask

    // Drive one cycle from posedge+1, advance the model by what the handshake rules say happens.
    task automatic step(input logic v, input logic [DW-1:0] d);
        logic x;
        ins_valid = v;
        ins       = d;
        x = v && m_ready();
        @(posedge clk);
        #1;
        if (x) begin
            if (d !== EXP && !m_mis) begin
                m_mis = 1'b1;
                m_fb  = d;
                m_fi  = m_count;
            end
            m_count = m_count + 1;
            m_gap   = 0;
        end else if (m_gap < 1000) begin
            m_gap = m_gap + 1;
        end
    endtask

    task automatic do_reset();
        ins_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_chk++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state actual=%h required=%h", act_vec(), exp_vec());
        end
        n_chk++;
        if ({ins_ready2, count2, mismatch2, done2} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state2 actual=%b required=%b",
                     {ins_ready2, count2, mismatch2, done2}, {1'b1, 4'd0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int done_at;
        do_reset();
        done_at = 7 * (SE + 1) + 1;
        for (int s = 1; s <= 30; s++) begin
            step(1'b1, EXP);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream cyc=%0d actual=%h required=%h", s, act_vec(), exp_vec());
            end
            if (s == done_at - 1 || s == done_at) begin
                n_chk++;
                if (done !== (s == done_at)) begin
                    n_fail++;
                    $display("FAIL stream_done_time cyc=%0d actual=%b required=%b", s, done, (s == done_at));
                end
            end
        end
        n_chk++;
        if ({done, ins_ready, mismatch, count} !== {1'b1, 1'b0, 1'b0, 16'd8}) begin
            n_fail++;
            $display("FAIL stream_final actual=%h required=%h",
                     {done, ins_ready, mismatch, count}, {1'b1, 1'b0, 1'b0, 16'd8});
        end
    endtask

    task automatic test_mismatch();
        logic [DW-1:0] d;
        do_reset();
        for (int s = 0; s < 30; s++) begin
            d = (m_count == 3) ? 32'h000A7C99 : (m_count == 5) ? 32'h0 : EXP;
            step(1'b1, d);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL mismatch cyc=%0d actual=%h required=%h", s, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if ({mismatch, first_bad, first_bad_idx, done} !== {1'b1, 32'h000A7C99, 16'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL mismatch_capture actual=%h required=%h",
                     {mismatch, first_bad, first_bad_idx, done}, {1'b1, 32'h000A7C99, 16'd3, 1'b1});
        end
    endtask

    task automatic test_random_valid();
        logic          v;
        logic [DW-1:0] d;
        do_reset();
        for (int s = 0; s < 80; s++) begin
            v = (s < 24) ? ((s % 2) == 0) : 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? (EXP ^ (32'd1 << $urandom_range(0, 31))) : EXP;
            step(v, d);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_valid cyc=%0d actual=%h required=%h", s, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < 40 && m_count < 4; s++) begin
            step(1'b1, EXP);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=%h", act_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 12; s++) begin
            step(1'b1, (m_count == 0) ? 32'hDEADBEEF : EXP);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL after_reset cyc=%0d actual=%h required=%h", s, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if ({mismatch, first_bad, first_bad_idx} !== {1'b1, 32'hDEADBEEF, 16'd0}) begin
            n_fail++;
            $display("FAIL after_reset_idx actual=%h required=%h",
                     {mismatch, first_bad, first_bad_idx}, {1'b1, 32'hDEADBEEF, 16'd0});
        end
    endtask

    task automatic test_last_bad();
        logic prev_md;
        do_reset();
        prev_md = 1'b0;
        for (int s = 0; s < 30; s++) begin
            step(1'b1, (m_count == 7) ? 32'h00000001 : EXP);
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL last_bad cyc=%0d actual=%h required=%h", s, act_vec(), exp_vec());
            end
            if (done && !prev_md) begin
                n_chk++;
                if ({mismatch, first_bad_idx} !== {1'b1, 16'd7}) begin
                    n_fail++;
                    $display("FAIL last_bad_same_edge actual=%h required=%h",
                             {mismatch, first_bad_idx}, {1'b1, 16'd7});
                end
            end
            prev_md = done;
        end
    endtask

    task automatic test_wrap();
        int c2;
        do_reset();
        c2 = 0;
        ins_valid2 = 1'b1;
        for (int s = 0; s < 40; s++) begin
            ins2 = (s == 2) ? 32'h0 : EXP;
            n_chk++;
            if (ins_ready2 !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_ready cyc=%0d actual=%b required=1", s, ins_ready2);
            end
            @(posedge clk);
            #1;
            c2 = (c2 + 1) % 16;
            n_chk++;
            if ({count2, done2} !== {4'(c2), 1'b0}) begin
                n_fail++;
                $display("FAIL wrap_count cyc=%0d actual=%h required=%h", s, {count2, done2}, {4'(c2), 1'b0});
            end
        end
        ins_valid2 = 1'b0;
        n_chk++;
        if ({mismatch2, first_bad2, first_bad_idx2} !== {1'b1, 32'h0, 4'd2}) begin
            n_fail++;
            $display("FAIL wrap_mismatch actual=%h required=%h",
                     {mismatch2, first_bad2, first_bad_idx2}, {1'b1, 32'h0, 4'd2});
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mismatch();
        test_random_valid();
        test_reset_mid();
        test_last_bad();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
